// File: rtl/skipjack_pkg.sv
// Shared definitions for the Skipjack G-box engine.
//   F_TABLE        : the 256-entry Skipjack F substitution table
//   step_to_j0     : first key-byte index for a round counter, (4*step) mod 10
//   key_byte_index : (j0 + n) mod 10, the key-byte window with wrap 9 -> 0
//   fpc_is_legal   : legal F-box evaluations per clock (1, 2 or 4)
//   state_t        : engine FSM states
package skipjack_pkg;

  localparam logic [7:0] F_TABLE [256] = '{
    8'ha3, 8'hd7, 8'h09, 8'h83, 8'hf8, 8'h48, 8'hf6, 8'hf4, 8'hb3, 8'h21, 8'h15, 8'h78, 8'h99, 8'hb1, 8'haf, 8'hf9,
    8'he7, 8'h2d, 8'h4d, 8'h8a, 8'hce, 8'h4c, 8'hca, 8'h2e, 8'h52, 8'h95, 8'hd9, 8'h1e, 8'h4e, 8'h38, 8'h44, 8'h28,
    8'h0a, 8'hdf, 8'h02, 8'ha0, 8'h17, 8'hf1, 8'h60, 8'h68, 8'h12, 8'hb7, 8'h7a, 8'hc3, 8'he9, 8'hfa, 8'h3d, 8'h53,
    8'h96, 8'h84, 8'h6b, 8'hba, 8'hf2, 8'h63, 8'h9a, 8'h19, 8'h7c, 8'hae, 8'he5, 8'hf5, 8'hf7, 8'h16, 8'h6a, 8'ha2,
    8'h39, 8'hb6, 8'h7b, 8'h0f, 8'hc1, 8'h93, 8'h81, 8'h1b, 8'hee, 8'hb4, 8'h1a, 8'hea, 8'hd0, 8'h91, 8'h2f, 8'hb8,
    8'h55, 8'hb9, 8'hda, 8'h85, 8'h3f, 8'h41, 8'hbf, 8'he0, 8'h5a, 8'h58, 8'h80, 8'h5f, 8'h66, 8'h0b, 8'hd8, 8'h90,
    8'h35, 8'hd5, 8'hc0, 8'ha7, 8'h33, 8'h06, 8'h65, 8'h69, 8'h45, 8'h00, 8'h94, 8'h56, 8'h6d, 8'h98, 8'h9b, 8'h76,
    8'h97, 8'hfc, 8'hb2, 8'hc2, 8'hb0, 8'hfe, 8'hdb, 8'h20, 8'he1, 8'heb, 8'hd6, 8'he4, 8'hdd, 8'h47, 8'h4a, 8'h1d,
    8'h42, 8'hed, 8'h9e, 8'h6e, 8'h49, 8'h3c, 8'hcd, 8'h43, 8'h27, 8'hd2, 8'h07, 8'hd4, 8'hde, 8'hc7, 8'h67, 8'h18,
    8'h89, 8'hcb, 8'h30, 8'h1f, 8'h8d, 8'hc6, 8'h8f, 8'haa, 8'hc8, 8'h74, 8'hdc, 8'hc9, 8'h5d, 8'h5c, 8'h31, 8'ha4,
    8'h70, 8'h88, 8'h61, 8'h2c, 8'h9f, 8'h0d, 8'h2b, 8'h87, 8'h50, 8'h82, 8'h54, 8'h64, 8'h26, 8'h7d, 8'h03, 8'h40,
    8'h34, 8'h4b, 8'h1c, 8'h73, 8'hd1, 8'hc4, 8'hfd, 8'h3b, 8'hcc, 8'hfb, 8'h7f, 8'hab, 8'he6, 8'h3e, 8'h5b, 8'ha5,
    8'had, 8'h04, 8'h23, 8'h9c, 8'h14, 8'h51, 8'h22, 8'hf0, 8'h29, 8'h79, 8'h71, 8'h7e, 8'hff, 8'h8c, 8'h0e, 8'he2,
    8'h0c, 8'hef, 8'hbc, 8'h72, 8'h75, 8'h6f, 8'h37, 8'ha1, 8'hec, 8'hd3, 8'h8e, 8'h62, 8'h8b, 8'h86, 8'h10, 8'he8,
    8'h08, 8'h77, 8'h11, 8'hbe, 8'h92, 8'h4f, 8'h24, 8'hc5, 8'h32, 8'h36, 8'h9d, 8'hcf, 8'hf3, 8'ha6, 8'hbb, 8'hac,
    8'h5e, 8'h6c, 8'ha9, 8'h13, 8'h57, 8'h25, 8'hb5, 8'he3, 8'hbd, 8'ha8, 8'h3a, 8'h01, 8'h05, 8'h59, 8'h2a, 8'h46
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit fpc_is_legal(input int fpc);
    return (fpc == 1) || (fpc == 2) || (fpc == 4);
  endfunction

  // Round counter -> first key byte of its four-byte window.
  function automatic logic [3:0] step_to_j0(input logic [4:0] step);
    logic [6:0] t;
    t = {step, 2'b00};
    return 4'(t % 7'd10);
  endfunction

  // Key byte n positions into the window, wrapping 9 -> 0.
  function automatic logic [3:0] key_byte_index(input logic [3:0] j0, input logic [1:0] n);
    logic [4:0] t;
    t = {1'b0, j0} + {3'b000, n};
    return 4'((t >= 5'd10) ? (t - 5'd10) : t);
  endfunction

endpackage

// File: rtl/skipjack_g_engine_f_box.sv
// f_box: one Skipjack F-table lookup.
//   iword : 8-bit table index
//   oword : 8-bit F(iword)
module f_box
  import skipjack_pkg::*;
(
  input  logic [7:0] iword,
  output logic [7:0] oword
);

  assign oword = F_TABLE[iword];

endmodule

// File: rtl/skipjack_g_engine.sv
// skipjack_g_engine: iterative Skipjack G permutation (and optional G-inverse).
// Evaluates FPC Feistel stages per clock; a result appears 4/FPC cycles after
// the accept edge and is held until the consumer takes it.
//
// Build option: define SKIPJACK_GINV_EN to add G-inverse (selected by in_inv).
// Without it in_inv is ignored and G is always computed.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : request handshake (in_ready only in IDLE)
//   in_data  [15:0]       : {g1, g2} for G, {p, q} for G-inverse
//   in_step  [4:0]        : round counter selecting the key-byte window
//   in_key   [0:79]       : cryptovariable, byte b = in_key[8b +: 8]
//   in_inv                : 0 = G, 1 = G-inverse
//   out_valid / out_ready : result handshake
//   out_data [15:0]       : result, 0 whenever out_valid is 0
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, holds its data stable until that edge.
module skipjack_g_engine
  import skipjack_pkg::*;
#(
  parameter int FPC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [4:0]  in_step,
  input  logic [0:79] in_key,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  if (!fpc_is_legal(FPC)) begin : g_fpc_check
    $error("skipjack_g_engine: FPC must be 1, 2 or 4");
  end

  localparam logic [2:0] FPC_STEP = 3'(FPC);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [15:0] work_q;
  logic [0:79] key_q;
  logic [3:0]  j0_q;
  logic        accept;
  logic [2:0]  cnt_sum;
  logic        wrap;
  logic [15:0] result;
  logic [15:0] init_word;

`ifdef SKIPJACK_GINV_EN
  logic inv_q;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  // Carry out of the 2-bit counter marks the last group of stages.
  assign cnt_sum = {1'b0, cnt_q} + FPC_STEP;
  assign wrap    = cnt_sum[2];
  assign accept  = in_valid & in_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (wrap) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The working word is {x, y}; every stage maps it to {y, F(y ^ k) ^ x}.
  // G starts from {g1, g2} with keys j0..j3 and ends at {p, q}. G-inverse
  // starts from {q, p} with keys j3..j0 and ends at {g2, g1}, so it reuses the
  // same stage with a swapped word and a reversed key window.
  logic [15:0] chain [FPC+1];
  assign chain[0] = work_q;

  for (genvar e = 0; e < FPC; e++) begin : g_stage
    logic [1:0] stage_n;
    logic [1:0] win_n;
    logic [3:0] kidx;
    logic [7:0] kbyte;
    logic [7:0] f_in;
    logic [7:0] f_out;

    assign stage_n = cnt_q + 2'(e);
`ifdef SKIPJACK_GINV_EN
    assign win_n = inv_q ? ~stage_n : stage_n;
`else
    assign win_n = stage_n;
`endif
    assign kidx  = key_byte_index(j0_q, win_n);
    assign kbyte = key_q[8*kidx +: 8];
    assign f_in  = chain[e][7:0] ^ kbyte;

    f_box u_f_box (
      .iword (f_in),
      .oword (f_out)
    );

    assign chain[e+1] = {chain[e][7:0], f_out ^ chain[e][15:8]};
  end

`ifdef SKIPJACK_GINV_EN
  assign init_word = in_inv ? {in_data[7:0], in_data[15:8]} : in_data;
  assign result    = inv_q ? {work_q[7:0], work_q[15:8]} : work_q;
`else
  assign init_word = in_data;
  assign result    = work_q;
`endif

  assign out_data = (state_q == ST_DONE) ? result : 16'h0000;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      work_q <= 16'h0000;
      key_q  <= '0;
      j0_q   <= 4'd0;
`ifdef SKIPJACK_GINV_EN
      inv_q  <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q  <= 2'd0;
      work_q <= init_word;
      key_q  <= in_key;
      j0_q   <= step_to_j0(in_step);
`ifdef SKIPJACK_GINV_EN
      inv_q  <= in_inv;
`endif
    end else if (state_q == ST_BUSY) begin
      cnt_q  <= cnt_sum[1:0];
      work_q <= chain[FPC];
    end
  end

endmodule

// File: doc/skipjack_g_engine.md
SKIPJACK_G_ENGINE -- requirements
Module: skipjack_g_engine

Interface
REQ-001 SHALL have parameter FPC, default 1, meaning F-box evaluations per clock; legal values are 1, 2 and 4, and any other value is an elaboration error.
REQ-002 clk  in  1  the only clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  an input request is present.
REQ-005 in_ready  out  1  the engine accepts a request in this cycle.
REQ-006 in_data  in  16  input word: g1 = [15:8], g2 = [7:0].
REQ-007 in_step  in  5  round counter; it selects the key-byte window.
REQ-008 in_key  in  80  cryptovariable, declared [0:79]; byte b = in_key[8b +: 8].
REQ-009 in_inv  in  1  0 = G, 1 = G-inverse.
REQ-010 out_valid  out  1  a result is held on out_data.
REQ-011 out_ready  in  1  the consumer takes the result.
REQ-012 out_data  out  16  the result word.

Function
REQ-013 SHALL compute j0 = (4*in_step) mod 10 and jn = (j0+n) mod 10 for n = 1..3.
REQ-014 G SHALL be computed as: h = F(g2^k[j0])^g1; i = F(h^k[j1])^g2; p = F(i^k[j2])^h; q = F(p^k[j3])^i; out = {p,q}.
REQ-015 G-inverse SHALL take in_data as {p,q} and compute: i = F(p^k[j3])^q; h = F(i^k[j2])^p; g2 = F(h^k[j1])^i; g1 = F(g2^k[j0])^h; out = {g1,g2}.
REQ-016 SHALL be a state machine with three states: IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an accept is in_valid and in_ready in the same cycle.
REQ-018 On accept, SHALL latch in_data, the key, j0 and in_inv, clear the stage counter, and go to BUSY; inputs after the accept cycle SHALL not affect the result.
REQ-019 In BUSY, SHALL evaluate FPC Feistel stages per cycle, in the order given in REQ-014 or REQ-015.
REQ-020 The 2-bit stage counter SHALL advance by FPC each cycle, wrap modulo 4, and cause a move to DONE on the cycle it wraps.
REQ-021 Latency from the accept edge to out_valid=1 SHALL be exactly 4/FPC cycles.
REQ-022 In DONE, out_valid SHALL be 1 and out_data SHALL be stable until out_ready=1, and that handshake SHALL return the engine to IDLE.
REQ-023 In_valid held high through DONE SHALL be accepted only in the first IDLE cycle after the handshake, giving at most one operation in flight.
REQ-024 out_data SHALL be 0 whenever out_valid=0.
REQ-025 in_step values 0..31 SHALL all be legal, and the window SHALL wrap 9->0 (e.g. step 2 gives bytes 8, 9, 0, 1).

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, out_valid=0, out_data=0 and stage counter=0, and SHALL clear the data and key registers.
REQ-027 Reset in BUSY or DONE SHALL abort the operation with no result emitted.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-029 SHALL use the macro SKIPJACK_GINV_EN.
REQ-030 With SKIPJACK_GINV_EN defined, SHALL provide G-inverse as in REQ-015.
REQ-031 Without SKIPJACK_GINV_EN, the inverse datapath SHALL be compiled out, in_inv SHALL be ignored, and G SHALL always be computed.
REQ-032 The port list SHALL be identical with and without SKIPJACK_GINV_EN.

Structure
REQ-033 The shared package skipjack_pkg SHALL hold: the 256-entry F-table constant, a key-byte-index function ((4*step) mod 10 with wrap), the state enum type, and FPC legality checks.
REQ-034 The F lookup SHALL be done by the existing f_box sub-module (iword 8 in, oword 8 out), instantiated FPC times.
REQ-035 No other sub-module SHALL be used.

Verification
REQ-036 SHALL apply the Skipjack spec vector: key 00998877665544332211, block 33221100ddccbbaa, through 32 G/A/B rounds built around the engine, and SHALL check ciphertext 2587cae27a12d300.
REQ-037 SHALL use G-inverse (SKIPJACK_GINV_EN) to decrypt ciphertext 2587cae27a12d300 and SHALL check plaintext 33221100ddccbbaa.
REQ-038 SHALL check, for FPC=1, 2 and 4, out_valid rising at 4, 2 and 1 cycles after accept; with out_ready=1 back-to-back, one result every 4/FPC+2 cycles.
REQ-039 SHALL hold out_ready=0 for 10 cycles in DONE and check out_data stable, in_ready=0, and in_valid not accepted.
REQ-040 SHALL assert rst_n=0 mid-BUSY and check out_valid=0 and out_data=0 on the next cycle, in_ready=1 after release, and a fresh request giving the correct result.
REQ-041 SHALL check in_step 2 and 7 against a software model for key-byte wrap, and in_step 31, for each of random in_data.
